alu_arbiter: RTL and testbench

Two-requester scheduler that shares the single combinational `alu` instance (ADD/SUB/AND/OR, 32-bit) between two independent clients, such as a decode path and a debug/test port.
- Accepts one operation at a time over a valid/ready handshake, with round-robin grant.
- Registers the operands, drives the ALU for one execute cycle, and holds the result until the owner takes it.
- Sits between the requesters and the `alu` instance; it is the only driver of the ALU's `A`/`B`/`op` inputs.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu.sv | 22 ++
 rtl/alu_arbiter.sv | 84 ++++++++
 tb/tb_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the arbiter FSM state encoding.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two ALU requesters, the result consumer and the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);

  // Valid/ready: a transfer happens on a rising edge where both valid and ready
  // are high; a requester holds its payload stable until that edge, and
  // may withdraw valid earlier with no effect.
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_out;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_out
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_out
  );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU: ADD, SUB (A-B), AND, OR; arithmetic wraps, no flags.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    case (op)
      ALU_ADD: result = A + B;
      ALU_SUB: result = A - B;
      ALU_AND: result = A & B;
      default: result = A | B;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one ALU between two requesters; one operation
// in flight, IDLE -> EXEC -> RESP, result held until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output state_t        dbg_state
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             id_q;
  logic             last_grant;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] alu_y;
  logic             grant0;
  logic             grant1;
  logic             accept;

  // Requester 1 wins when alone or when requester 0 was served last.
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
  assign grant0 = bus.req0_valid && !grant1;
  assign accept = (state == ST_IDLE) && !rst && (bus.req0_valid || bus.req1_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)        state_nxt = ST_EXEC;
      ST_EXEC:                    state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = (state == ST_IDLE) && !rst && grant0;
    bus.req1_ready = (state == ST_IDLE) && !rst && grant1;
    bus.rsp_valid  = (state == ST_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= ALU_ADD;
      id_q       <= 1'b0;
      out_q      <= '0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        a_q  <= grant1 ? bus.req1_a  : bus.req0_a;
        b_q  <= grant1 ? bus.req1_b  : bus.req0_b;
        op_q <= grant1 ? bus.req1_op : bus.req0_op;
        id_q <= grant1;
      end
      if (state == ST_EXEC) out_q <= alu_y;
      if ((state == ST_RESP) && bus.rsp_ready) last_grant <= id_q;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .A      (a_q),
    .B      (b_q),
    .op     (op_q),
    .result (alu_y)
  );

  assign bus.rsp_id  = id_q;
  assign bus.rsp_out = out_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single ops plus hand-written
// tie, backpressure and mid-operation reset sequences.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     checks = 0;
  int     errors = 0;
  logic [W-1:0] exp_q[$];
  vec_t   vecs[6];

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op);
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end
  endtask

  task automatic drop_req(input logic id);
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic wait_ready(input logic id, input string name);
    int n = 0;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, " ready"}, id ? bus.req1_ready : bus.req0_ready, 1);
  endtask

  // Called at the negedge of the EXEC cycle; walks into RESP.
  task automatic expect_rsp(input logic id, input string name);
    logic [W-1:0] exp;
    exp = 'x;
    #1;
    check({name, " exec rsp_valid"}, bus.rsp_valid, 0);
    check({name, " exec state"}, dbg_state, ST_EXEC);
    @(negedge clk); #1;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check({name, " rsp_valid"}, bus.rsp_valid, 1);
    check({name, " rsp_out"}, bus.rsp_out, exp);
    check({name, " rsp_id"}, bus.rsp_id, id);
  endtask

  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic [W-1:0] exp, input string name);
    @(negedge clk);
    drive_req(id, a, b, op);
    #1;
    wait_ready(id, name);
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    drop_req(id);
    expect_rsp(id, name);
  endtask

  // Both requesters valid: first must win, then the other follows once IDLE.
  task automatic tie_pair(input logic first,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [1:0] op0,
                          input logic [W-1:0] e0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] op1,
                          input logic [W-1:0] e1, input string name);
    @(negedge clk);
    drive_req(1'b0, a0, b0, op0);
    drive_req(1'b1, a1, b1, op1);
    #1;
    check({name, " winner ready"}, first ? bus.req1_ready : bus.req0_ready, 1);
    check({name, " loser ready"}, first ? bus.req0_ready : bus.req1_ready, 0);
    exp_q.push_back(first ? e1 : e0);
    @(posedge clk);
    @(negedge clk);
    drop_req(first);
    expect_rsp(first, {name, " first"});
    check({name, " loser blocked in RESP"}, first ? bus.req0_ready : bus.req1_ready, 0);
    @(negedge clk); #1;
    check({name, " loser ready in IDLE"}, first ? bus.req0_ready : bus.req1_ready, 1);
    exp_q.push_back(first ? e0 : e1);
    @(posedge clk);
    @(negedge clk);
    drop_req(!first);
    expect_rsp(!first, {name, " second"});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_000A, 32'h0000_000B, ALU_ADD, 32'd21};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0000_0001, ALU_SUB, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, ALU_ADD, 32'h0000_0001};
    vecs[3] = '{1'b1, 32'h0000_F0F0, 32'h0000_FF00, ALU_AND, 32'h0000_F000};
    vecs[4] = '{1'b0, 32'h1234_0000, 32'h0000_5678, ALU_OR,  32'h1234_5678};
    vecs[5] = '{1'b1, 32'h0000_0005, 32'h0000_0007, ALU_SUB, 32'hFFFF_FFFE};

    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = ALU_ADD;
    bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = ALU_ADD;
    bus.rsp_ready  = 1'b0;

    // Reset with requests pending: nothing may be granted.
    repeat (2) @(negedge clk);
    #1;
    check("reset req0_ready", bus.req0_ready, 0);
    check("reset req1_ready", bus.req1_ready, 0);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset rsp_out", bus.rsp_out, 0);
    check("reset rsp_id", bus.rsp_id, 0);
    check("reset state", dbg_state, ST_IDLE);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle rsp_valid", bus.rsp_valid, 0);
    check("idle req0_ready", bus.req0_ready, 0);
    check("idle req1_ready", bus.req1_ready, 0);
    check("idle state", dbg_state, ST_IDLE);

    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp,
             $sformatf("vec%0d", i));
      @(negedge clk); #1;
      check($sformatf("vec%0d back to idle", i), dbg_state, ST_IDLE);
    end

    // Requester 1 was served last, so requester 0 takes the first tie.
    tie_pair(1'b0, 32'hB, 32'hA, ALU_SUB, 32'd1, 32'h4, 32'h5, ALU_OR, 32'd5, "tie_a");
    run_op(1'b0, 32'd2, 32'd3, ALU_ADD, 32'd5, "pre_tie_b");
    @(negedge clk);
    tie_pair(1'b1, 32'hFF, 32'h0F, ALU_AND, 32'h0F, 32'd10, 32'd20, ALU_ADD, 32'd30, "tie_b");

    // Backpressure on a held result.
    bus.rsp_ready = 1'b0;
    run_op(1'b1, 32'h4, 32'h5, ALU_AND, 32'h4, "bp");
    drive_req(1'b0, 32'd3, 32'd4, ALU_ADD);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp hold%0d rsp_valid", i), bus.rsp_valid, 1);
      check($sformatf("bp hold%0d rsp_out", i), bus.rsp_out, 32'h4);
      check($sformatf("bp hold%0d rsp_id", i), bus.rsp_id, 1);
      check($sformatf("bp hold%0d req0_ready", i), bus.req0_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("bp first idle req0_ready", bus.req0_ready, 1);
    exp_q.push_back(32'd7);
    @(posedge clk);
    @(negedge clk);
    drop_req(1'b0);
    expect_rsp(1'b0, "bp follow");
    @(negedge clk);

    // Reset while in EXEC.
    drive_req(1'b1, 32'd9, 32'd2, ALU_SUB);
    #1;
    wait_ready(1'b1, "rst_exec");
    @(posedge clk);
    @(negedge clk);
    drop_req(1'b1);
    #1;
    check("rst_exec in exec", dbg_state, ST_EXEC);
    rst = 1'b1;
    #1;
    check("rst_exec rsp_valid", bus.rsp_valid, 0);
    check("rst_exec state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check($sformatf("rst_exec no rsp%0d", i), bus.rsp_valid, 0);
    end
    run_op(1'b0, 32'd6, 32'd6, ALU_SUB, 32'd0, "after_rst_exec");
    @(negedge clk);

    // Reset while holding a response.
    bus.rsp_ready = 1'b0;
    run_op(1'b1, 32'd8, 32'd1, ALU_OR, 32'd9, "rst_resp");
    rst = 1'b1;
    #1;
    check("rst_resp rsp_valid", bus.rsp_valid, 0);
    check("rst_resp rsp_out", bus.rsp_out, 0);
    check("rst_resp rsp_id", bus.rsp_id, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check($sformatf("rst_resp no rsp%0d", i), bus.rsp_valid, 0);
    end
    tie_pair(1'b0, 32'd100, 32'd1, ALU_ADD, 32'd101, 32'd6, 32'd3, ALU_AND, 32'd2, "tie_after_rst");

    check("expected queue drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
